// File: rtl/zuc256_pkg.sv
// zuc256_pkg
// Shared definitions for the ZUC-256 job scheduler: state encoding, the
// default job-length width and a small channel-to-one-hot helper.
package zuc256_pkg;

    localparam int LEN_W_DEFAULT = 16;

    localparam int ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_INIT  = 3'd1;
    localparam logic [ST_W-1:0] ST_IWAIT = 3'd2;
    localparam logic [ST_W-1:0] ST_GEN   = 3'd3;
    localparam logic [ST_W-1:0] ST_GWAIT = 3'd4;
    localparam logic [ST_W-1:0] ST_OUT   = 3'd5;

    // The core command is ignored in the first wait cycle, so the
    // wait timer is loaded with 1 and counts down to its terminal value.
    localparam int WAIT_W = 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = 1'b1;

    function automatic logic [1:0] ch_onehot(input logic ch);
        return ch ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/zuc256_rr_arb.sv
// zuc256_rr_arb
// Two-way round-robin arbiter. Grant is combinational from req and the
// pointer; the pointer moves to the non-granted channel whenever a grant is
// taken.
//   clk, reset_n : clock, asynchronous active-low reset
//   req          : per-channel request (already masked by the caller)
//   take         : caller consumes the current grant this cycle
//   gnt_vld      : some channel is granted
//   gnt_ch       : index of the granted channel
module zuc256_rr_arb (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic       gnt_vld,
    output logic       gnt_ch
);

    logic ptr;

    always_comb begin
        gnt_vld = |req;
        gnt_ch  = (req == 2'b11) ? ptr : req[1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= 1'b0;
        end else if (take && gnt_vld) begin
            ptr <= ~gnt_ch;
        end
    end

endmodule

// File: rtl/zuc256_sched.sv
// zuc256_sched
// Schedules keystream jobs from two channels onto one shared ZUC-256 core.
// A granted job is initialised once, then one word is generated per
// core_next command and handed out through a valid/ready port.
//   clk, reset_n          : clock, asynchronous active-low reset
//   req[1:0], ack[1:0]    : job request / one-cycle acceptance pulse
//   key0/1, iv0/1, len0/1 : per-channel job parameters, sampled at grant
//   out_valid/ready/word  : keystream output handshake
//   out_ch, out_last      : owning channel, final word of the job
//   busy                  : scheduler is not idle
//   core_init, core_next  : command pulses to the core
//   core_key, core_iv     : latched job key/IV
//   core_z, core_ready    : core keystream word and idle flag
//
// state    | meaning
// IDLE     | arbitrate requests, latch job parameters
// INIT     | core_init pulse
// IWAIT    | wait for the core to finish initialisation
// GEN      | core_next pulse
// GWAIT    | wait for the keystream word, then register it
// OUT      | present word until the consumer takes it
module zuc256_sched
    import zuc256_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       req,
    input  logic [255:0]     key0,
    input  logic [255:0]     key1,
    input  logic [127:0]     iv0,
    input  logic [127:0]     iv1,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    output logic [1:0]       ack,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_word,
    output logic             out_ch,
    output logic             out_last,
    output logic             busy,
    output logic             core_init,
    output logic             core_next,
    output logic [255:0]     core_key,
    output logic [127:0]     core_iv,
    input  logic [31:0]      core_z,
    input  logic             core_ready
);

    logic [ST_W-1:0]   state;
    logic [LEN_W-1:0]  rem_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        arb_req;
    logic              gnt_vld;
    logic              gnt_ch;
    logic [LEN_W-1:0]  len_sel;

    // ack is registered, so the requester still holds req during the ack
    // cycle; masking it stops IDLE from granting the same request twice.
    assign arb_req = req & ~ack;
    assign len_sel = gnt_ch ? len1 : len0;

    zuc256_rr_arb u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (arb_req),
        .take    (state == ST_IDLE),
        .gnt_vld (gnt_vld),
        .gnt_ch  (gnt_ch)
    );

    assign core_init = (state == ST_INIT);
    assign core_next = (state == ST_GEN);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            ack       <= 2'b00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_ch    <= 1'b0;
            out_word  <= '0;
            core_key  <= '0;
            core_iv   <= '0;
            rem_cnt   <= '0;
            wait_cnt  <= '0;
        end else begin
            ack <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        ack      <= ch_onehot(gnt_ch);
                        out_ch   <= gnt_ch;
                        core_key <= gnt_ch ? key1 : key0;
                        core_iv  <= gnt_ch ? iv1 : iv0;
                        rem_cnt  <= len_sel;
                        // a zero-length job is acknowledged and dropped
                        if (len_sel != '0) begin
                            state <= ST_INIT;
                        end
                    end
                end
                ST_INIT: begin
                    wait_cnt <= WAIT_LOAD;
                    state    <= ST_IWAIT;
                end
                ST_IWAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else if (core_ready) begin
                        state <= ST_GEN;
                    end
                end
                ST_GEN: begin
                    wait_cnt <= WAIT_LOAD;
                    state    <= ST_GWAIT;
                end
                ST_GWAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else if (core_ready) begin
                        out_word  <= core_z;
                        out_valid <= 1'b1;
                        out_last  <= (rem_cnt == LEN_W'(1));
                        state     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        rem_cnt   <= rem_cnt - 1'b1;
                        state     <= out_last ? ST_IDLE : ST_GEN;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zuc256_sched.sv
// tb_zuc256_sched
// Directed bench for zuc256_sched with a behavioural core stub. Expected
// acks and output words are queued by the stimulus; a negedge monitor pops
// and compares whenever the DUT acks or hands over a word.
module tb_zuc256_sched;

    localparam int LW = 16;

    logic           clk;
    logic           reset_n;
    logic [1:0]     req;
    logic [255:0]   key0, key1;
    logic [127:0]   iv0, iv1;
    logic [LW-1:0]  len0, len1;
    logic [1:0]     ack;
    logic           out_valid;
    logic           out_ready;
    logic [31:0]    out_word;
    logic           out_ch;
    logic           out_last;
    logic           busy;
    logic           core_init;
    logic           core_next;
    logic [255:0]   core_key;
    logic [127:0]   core_iv;
    logic [31:0]    core_z;
    logic           core_ready;

    zuc256_sched #(.LEN_W(LW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .key0       (key0),
        .key1       (key1),
        .iv0        (iv0),
        .iv1        (iv1),
        .len0       (len0),
        .len1       (len1),
        .ack        (ack),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_word   (out_word),
        .out_ch     (out_ch),
        .out_last   (out_last),
        .busy       (busy),
        .core_init  (core_init),
        .core_next  (core_next),
        .core_key   (core_key),
        .core_iv    (core_iv),
        .core_z     (core_z),
        .core_ready (core_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] w;
        logic        ch;
        logic        last;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] ack_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_init = 0;
    int         n_next = 0;
    logic [31:0] zv [64];
    int         zn = 0;
    int         stub_dly_init = 2;
    int         stub_dly_next = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h need %h", nm, act, want);
        end
    endtask

    // Core stub: after a command, ready drops for a programmable number of
    // cycles; the word for core_next only becomes valid one cycle after the
    // command, so sampling in the first wait cycle picks up garbage.
    int          stall;
    int          zi;
    logic        zload;
    logic [31:0] zpend;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_ready <= 1'b1;
            stall      <= 0;
            zi         <= 0;
            core_z     <= '0;
            zload      <= 1'b0;
            zpend      <= '0;
        end else begin
            zload <= 1'b0;
            if (zload) core_z <= zpend;
            if (core_init) begin
                stall      <= stub_dly_init;
                core_ready <= (stub_dly_init == 0);
            end else if (core_next) begin
                stall      <= stub_dly_next;
                core_ready <= (stub_dly_next == 0);
                zpend      <= zv[zi % 64];
                zload      <= 1'b1;
                zi         <= zi + 1;
                core_z     <= 32'hDEAD_BEEF;
            end else if (stall > 1) begin
                stall <= stall - 1;
            end else if (stall == 1) begin
                stall      <= 0;
                core_ready <= 1'b1;
            end
        end
    end

    // Monitor / scoreboard
    logic        hold_p = 1'b0;
    logic [31:0] hold_w;
    logic        hold_ch, hold_last;
    always @(negedge clk) begin
        exp_t e;
        logic [1:0] ea;
        if (hold_p) begin
            chk("hold_valid", {255'b0, out_valid}, 256'd1);
            chk("hold_word", {224'b0, out_word}, {224'b0, hold_w});
            chk("hold_ch_last", {254'b0, out_ch, out_last}, {254'b0, hold_ch, hold_last});
        end
        hold_p    = out_valid && !out_ready;
        hold_w    = out_word;
        hold_ch   = out_ch;
        hold_last = out_last;

        if (ack != 2'b00) begin
            if (ack_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_ack: got %b need none", ack);
            end else begin
                ea = ack_q.pop_front();
                chk("ack", {254'b0, ack}, {254'b0, ea});
            end
        end

        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_word: got %h need none", out_word);
            end else begin
                e = exp_q.pop_front();
                chk("word", {224'b0, out_word}, {224'b0, e.w});
                chk("word_ch", {255'b0, out_ch}, {255'b0, e.ch});
                chk("word_last", {255'b0, out_last}, {255'b0, e.last});
            end
        end

        if (core_init || core_next) begin
            n_init += int'(core_init);
            n_next += int'(core_next);
            chk("cmd_exclusive", {255'b0, core_init & core_next}, 256'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (ack[0]) req[0] = 1'b0;
        if (ack[1]) req[1] = 1'b0;
    endtask

    task automatic push_words(input logic ch, input int len);
        exp_t e;
        for (int i = 0; i < len; i++) begin
            e.w    = zv[zn % 64];
            e.ch   = ch;
            e.last = (i == len - 1);
            exp_q.push_back(e);
            zn++;
        end
    endtask

    task automatic drain(input int budget, input string nm);
        int k;
        for (k = 0; k < budget; k++) begin
            if (exp_q.size() == 0 && ack_q.size() == 0 && !busy && !out_valid && req == 2'b00)
                break;
            step();
        end
        n_cmp++;
        if (k >= budget) begin
            n_bad++;
            $display("FAIL %s_timeout: got %0d words pending, need 0", nm, exp_q.size());
        end
    endtask

    task automatic wait_for(input int which, input int budget, input string nm);
        int k;
        for (k = 0; k < budget; k++) begin
            if ((which == 0 && out_valid) || (which == 1 && core_next) || (which == 2 && core_ready))
                break;
            step();
        end
        n_cmp++;
        if (k >= budget) begin
            n_bad++;
            $display("FAIL %s_timeout: got no event, need event within %0d cycles", nm, budget);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        zn = 0;
        step();
    endtask

    int ni, nn;
    logic saw_valid;

    initial begin
        for (int k = 0; k < 64; k++) zv[k] = 32'hC0DE_0000 | k;
        zv[0] = 32'h58d0_3ad6;
        zv[1] = 32'h2e03_2ce2;
        req = 2'b00; out_ready = 1'b1;
        key0 = '0; key1 = '0; iv0 = '0; iv1 = '0; len0 = '0; len1 = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {254'b0, ack}, 256'd0);
        chk("rst_flags", {251'b0, out_valid, out_last, out_ch, busy, core_init | core_next}, 256'd0);
        chk("rst_word", {224'b0, out_word}, 256'd0);
        chk("rst_key", core_key, 256'd0);
        chk("rst_iv", {128'b0, core_iv}, 256'd0);
        reset_n = 1'b1;
        step();

        // Known keystream words on channel 0, two-word job
        zn = 0; key0 = '0; iv0 = '0; len0 = 16'd2;
        ni = n_init; nn = n_next;
        ack_q.push_back(2'b01);
        push_words(1'b0, 2);
        req = 2'b01;
        drain(200, "t1");
        chk("t1_pulses", {192'b0, 32'(n_init - ni), 32'(n_next - nn)}, {192'b0, 32'd1, 32'd2});

        // Both channels from reset: channel 0 first, channel 1 after it ends
        do_reset();
        key0 = {8{32'h0123_4567}}; key1 = {8{32'h89ab_cdef}};
        iv0 = {4{32'h1111_2222}};  iv1 = {4{32'h3333_4444}};
        len0 = 16'd2; len1 = 16'd3;
        ack_q.push_back(2'b01);
        ack_q.push_back(2'b10);
        push_words(1'b0, 2);
        push_words(1'b1, 3);
        req = 2'b11;
        drain(400, "t2");

        // Backpressure: 10 stalled cycles in OUT
        len0 = 16'd1;
        ack_q.push_back(2'b01);
        push_words(1'b0, 1);
        req = 2'b01;
        wait_for(0, 100, "t3_valid");
        out_ready = 1'b0;
        nn = n_next;
        repeat (10) step();
        chk("t3_no_next", {224'b0, 32'(n_next - nn)}, 256'd0);
        chk("t3_key", core_key, key0);
        chk("t3_iv", {128'b0, core_iv}, {128'b0, iv0});
        out_ready = 1'b1;
        drain(100, "t3");

        // Zero-length job on channel 1 (pointer was 1, must move to 0)
        len1 = 16'd0;
        ni = n_init;
        ack_q.push_back(2'b10);
        req = 2'b10;
        saw_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("t4_busy", {255'b0, busy}, 256'd0);
            saw_valid |= out_valid;
        end
        chk("t4_no_valid", {255'b0, saw_valid}, 256'd0);
        chk("t4_no_init", {224'b0, 32'(n_init - ni)}, 256'd0);
        len0 = 16'd1; len1 = 16'd1;
        ack_q.push_back(2'b01);
        ack_q.push_back(2'b10);
        push_words(1'b0, 1);
        push_words(1'b1, 1);
        req = 2'b11;
        drain(200, "t4");

        // Reset during GWAIT of a five-word job on channel 1
        stub_dly_next = 3;
        len1 = 16'd5;
        ack_q.push_back(2'b10);
        req = 2'b10;
        wait_for(1, 100, "t5_next");
        step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_flags", {250'b0, ack, out_valid, out_last, out_ch, busy}, 256'd0);
        chk("t5_cmds", {254'b0, core_init, core_next}, 256'd0);
        chk("t5_word", {224'b0, out_word}, 256'd0);
        chk("t5_key", core_key, 256'd0);
        chk("t5_iv", {128'b0, core_iv}, 256'd0);
        step();
        step();
        reset_n = 1'b1;
        zn = 0;
        stub_dly_next = 0;
        saw_valid = 1'b0;
        ni = n_init; nn = n_next;
        for (int k = 0; k < 20; k++) begin
            step();
            saw_valid |= out_valid | busy;
        end
        chk("t5_quiet", {255'b0, saw_valid}, 256'd0);
        chk("t5_no_cmd", {192'b0, 32'(n_init - ni), 32'(n_next - nn)}, 256'd0);

        // Slow core: ready low for 7 cycles after core_next
        stub_dly_next = 7;
        len0 = 16'd1;
        ni = n_init; nn = n_next;
        ack_q.push_back(2'b01);
        push_words(1'b0, 1);
        req = 2'b01;
        wait_for(1, 100, "t6_next");
        step();
        wait_for(2, 30, "t6_ready");
        chk("t6_valid_pre", {255'b0, out_valid}, 256'd0);
        step();
        chk("t6_valid_post", {255'b0, out_valid}, 256'd1);
        drain(100, "t6");
        chk("t6_pulses", {192'b0, 32'(n_init - ni), 32'(n_next - nn)}, {192'b0, 32'd1, 32'd1});

        chk("queues_empty", {192'b0, 32'(exp_q.size()), 32'(ack_q.size())}, 256'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/zuc256_sched.md
ZUC256_SCHED -- requirements
Module: zuc256_sched

Interface
REQ-001 Parameter LEN_W, default 16; width of per-job keystream length in 32-bit words.
REQ-002 Port clk  input  1  system clock, all logic rising-edge.
REQ-003 Port reset_n  input  1  reset; asynchronous, active-low.
REQ-004 Port req  input  2  per-channel job request; held high until the matching ack bit.
REQ-005 Port key0, key1  input  256 each  channel 0/1 key; sampled on ack.
REQ-006 Port iv0, iv1  input  128 each  channel 0/1 IV; sampled on ack.
REQ-007 Port len0, len1  input  LEN_W each  channel 0/1 word count; sampled on ack.
REQ-008 Port ack  output  2  one-cycle pulse; job of that channel accepted.
REQ-009 Port out_valid  output  1  out_word is valid.
REQ-010 Port out_ready  input  1  consumer accepts out_word.
REQ-011 Port out_word  output  32  keystream word.
REQ-012 Port out_ch  output  1  channel owning out_word.
REQ-013 Port out_last  output  1  out_word is the final word of the job.
REQ-014 Port busy  output  1  high in every state except IDLE.
REQ-015 Ports core_init, core_next  output  1 each  one-cycle command pulses to the shared ZUC-256 core.
REQ-016 Ports core_key (256) and core_iv (128)  output  latched job key/IV, stable from ack until job end.
REQ-017 Ports core_z  input  32, core_ready  input  1  core keystream word and idle flag.

Function
REQ-018 The FSM SHALL have exactly 6 states: IDLE, INIT, IWAIT, GEN, GWAIT, OUT.
REQ-019 IDLE: if any req bit is set, grant one channel, pulse its ack, latch key/iv/len/ch, and go to INIT. If the latched len is 0, stay in IDLE with no core command and no output.
REQ-020 Arbitration: one req bit set -> grant it; both set -> grant the channel named by the round-robin pointer.
REQ-021 The round-robin pointer SHALL be 0 after reset and SHALL point to the non-granted channel after each grant, including len=0 grants.
REQ-022 INIT: assert core_init for exactly one cycle, then go to IWAIT.
REQ-023 IWAIT and GWAIT: ignore core_ready in the first cycle; from the second cycle, core_ready=1 exits the state.
REQ-024 IWAIT exit SHALL go to GEN.
REQ-025 GEN: assert core_next for exactly one cycle, then go to GWAIT.
REQ-026 GWAIT exit: register core_z into out_word, set out_valid, and go to OUT.
REQ-027 out_last SHALL be 1 iff the remaining-word count equals 1.
REQ-028 OUT: out_word/out_ch/out_last SHALL be held stable while out_valid=1 and out_ready=0.
REQ-029 On out_valid and out_ready: clear out_valid and decrement the remaining count; if out_last -> IDLE, else -> GEN.
REQ-030 A req deasserted before ack SHALL be withdrawn, with no ack and no side effect; req changes during a job SHALL be ignored.
REQ-031 core_init and core_next SHALL never be asserted in the same cycle, and SHALL never be asserted outside INIT and GEN.
REQ-032 Minimum latency per word: 3 cycles (GEN, GWAIT x2) plus output backpressure.
REQ-033 IDLE SHALL re-arbitrate in the cycle after the last handshake; no bubble beyond IDLE.

Reset
REQ-034 Asynchronous assertion SHALL force: state IDLE; ack, out_valid, out_last, out_ch, busy, core_init, core_next = 0; out_word, core_key, core_iv = 0; RR pointer = 0.
REQ-035 Reset mid-job SHALL abandon the job; no output until a new req after release.

Structure
REQ-036 Shared package zuc256_pkg SHALL hold the state encoding constants and the LEN_W default.
REQ-037 Sub-module zuc256_rr_arb (2-way round-robin arbiter with pointer) is the only sub-module; the core is instantiated outside and wired to the core_* ports.

Verification
REQ-038 With the real zuc256_core: req=01, key0=0, iv0=0, len0=2 -> words 0x58d03ad6 then 0x2e032ce2; out_ch=0; out_last on the 2nd word only.
REQ-039 Both req set from reset -> ack=01 first, ack=10 after channel 0's last handshake; stub core returning a count tags each word with the correct out_ch.
REQ-040 out_ready held 0 for 10 cycles in OUT -> out_word is stable and no core_next pulse occurs.
REQ-041 len1=0 with req=10 -> ack pulse, no core_init, no out_valid, busy stays 0, RR pointer -> 0.
REQ-042 reset_n pulsed low during GWAIT of a len=5 job -> all outputs 0 immediately; no output after release until a new req.
REQ-043 Stub core holding core_ready low for 7 cycles after next -> scheduler waits with no extra pulses, and out_valid rises one cycle after core_ready rises.
